// File: rtl/regs_ctrl.sv
// regs_ctrl: command-side controller for a regs register file.
// Takes read/write commands over valid/ready, returns read data over a second
// valid/ready channel, and runs a clear sweep that zeroes every entry.
module regs_ctrl #(
  parameter int unsigned REGS_WIDTH      = 8,
  parameter int unsigned REGS_WIDTH_ADDR = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  // Command channel
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic                       i_cmd_wr,
  input  logic [REGS_WIDTH_ADDR-1:0] i_cmd_addr,
  input  logic [REGS_WIDTH-1:0]      i_cmd_data,
  // Response channel
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [REGS_WIDTH-1:0]      o_rsp_data,
  output logic [REGS_WIDTH_ADDR-1:0] o_rsp_addr,
  // Clear sweep / status
  input  logic                       i_clr,
  output logic                       o_busy,
  // Register file side
  output logic                       o_rf_wt_en,
  output logic [REGS_WIDTH_ADDR-1:0] o_rf_wt_addr,
  output logic [REGS_WIDTH-1:0]      o_rf_wt_data,
  output logic [REGS_WIDTH_ADDR-1:0] o_rf_rd_addr,
  input  logic [REGS_WIDTH-1:0]      i_rf_rd_data
);

  localparam logic [REGS_WIDTH_ADDR-1:0] LastAddr = '1;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StRsp,
    StClr
  } state_e;

  state_e                     state_q, state_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [REGS_WIDTH-1:0]      rsp_data_q, rsp_data_d;
  logic [REGS_WIDTH_ADDR-1:0] rsp_addr_q, rsp_addr_d;
  logic                       wt_en_q, wt_en_d;
  logic [REGS_WIDTH_ADDR-1:0] wt_addr_q, wt_addr_d;
  logic [REGS_WIDTH-1:0]      wt_data_q, wt_data_d;
  logic [REGS_WIDTH_ADDR-1:0] rd_addr_q, rd_addr_d;
  // Address being written by the sweep in the current cycle.
  logic [REGS_WIDTH_ADDR-1:0] clr_cnt_q, clr_cnt_d;

  // Clear takes priority, so ready drops whenever a sweep is requested.
  assign o_cmd_ready = (state_q == StIdle) && !i_clr && !i_rst;
  assign o_busy      = (state_q != StIdle);

  // Next-state and registered-output logic; write enable is a single-cycle pulse.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    wt_en_d     = 1'b0;
    wt_addr_d   = wt_addr_q;
    wt_data_d   = wt_data_q;
    rd_addr_d   = rd_addr_q;
    clr_cnt_d   = clr_cnt_q;

    case (state_q)
      StIdle: begin
        if (i_clr) begin
          // First sweep write is issued straight away so entries 0..N-1 land
          // in the N cycles following the request.
          clr_cnt_d = '0;
          wt_en_d   = 1'b1;
          wt_addr_d = '0;
          wt_data_d = '0;
          state_d   = StClr;
        end else if (i_cmd_valid) begin
          if (i_cmd_wr) begin
            wt_en_d   = 1'b1;
            wt_addr_d = i_cmd_addr;
            wt_data_d = i_cmd_data;
          end else begin
            rd_addr_d  = i_cmd_addr;
            rsp_addr_d = i_cmd_addr;
            state_d    = StRd;
          end
        end
      end

      StRd: begin
        rsp_data_d  = i_rf_rd_data;
        rsp_valid_d = 1'b1;
        state_d     = StRsp;
      end

      StRsp: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      StClr: begin
        if (clr_cnt_q == LastAddr) begin
          state_d = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          wt_en_d   = 1'b1;
          wt_addr_d = clr_cnt_q + 1'b1;
          wt_data_d = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset that aborts any activity.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      wt_en_q     <= 1'b0;
      wt_addr_q   <= '0;
      wt_data_q   <= '0;
      rd_addr_q   <= '0;
      clr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      wt_en_q     <= wt_en_d;
      wt_addr_q   <= wt_addr_d;
      wt_data_q   <= wt_data_d;
      rd_addr_q   <= rd_addr_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_addr   = rsp_addr_q;
  assign o_rf_wt_en   = wt_en_q;
  assign o_rf_wt_addr = wt_addr_q;
  assign o_rf_wt_data = wt_data_q;
  assign o_rf_rd_addr = rd_addr_q;

endmodule
